// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, control FSM state encoding, ALU and next-PC select codes.
// Also defines the instruction-class flags produced by op_decode.
package cpu_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // All eight 3-bit codes are taken by the working states, so HALT needs a fourth bit.
  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_LS = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB_L   = 4'b0100,
    S_EXE_B  = 4'b0101,
    S_EXE_A  = 4'b0110,
    S_WB_A   = 4'b0111,
    S_HALT   = 4'b1000
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic is_r;
    logic is_imm;
    logic is_branch;
    logic is_mem;
    logic is_jump;
    logic is_halt;
  } op_class_t;

  function automatic logic [2:0] alu_op_of(input logic [5:0] op);
    case (op)
      OP_SUB:        alu_op_of = ALU_SUB;
      OP_OR, OP_ORI: alu_op_of = ALU_OR;
      OP_AND:        alu_op_of = ALU_AND;
      OP_SLL:        alu_op_of = ALU_SLL;
      OP_SLT:        alu_op_of = ALU_SLT;
      default:       alu_op_of = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/op_decode.sv
// Combinational opcode classifier; an opcode matching no class is treated as a nop.
module op_decode
  import cpu_pkg::*;
(
  input  logic [5:0] op,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLL, OP_SLT: cls.is_r      = 1'b1;
      OP_ADDI, OP_ORI:                               cls.is_imm    = 1'b1;
      OP_BEQ, OP_BNE:                                cls.is_branch = 1'b1;
      OP_SW, OP_LW:                                  cls.is_mem    = 1'b1;
      OP_J:                                          cls.is_jump   = 1'b1;
      OP_HALT:                                       cls.is_halt   = 1'b1;
      default:                                       cls           = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences IF/ID/EXE/MEM/WB per instruction, drives all datapath
// enables and selects, and counts retired instructions (one per PCWre pulse).
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  output logic             PCWre,
  output logic [1:0]       PCSrc,
  output logic             IRWre,
  output logic             RegWre,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic             ExtSel,
  output logic             mRD,
  output logic             mWR,
  output logic             DBDataSrc,
  output logic             halted,
  output logic [CNT_W-1:0] inst_count
);

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic [5:0] dec_op;
  op_class_t  cls;
  logic       taken;

  // In ID the latched opcode is not yet available, so decode straight from the IR field.
  assign dec_op = (state_q == S_ID) ? opcode : op_q;

  op_decode u_op_decode (
    .op  (dec_op),
    .cls (cls)
  );

  assign taken = ((op_q == OP_BEQ) & zero) | ((op_q == OP_BNE) & ~zero);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= S_IF;
      op_q       <= '0;
      inst_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) op_q <= opcode;
      if (PCWre) inst_count <= inst_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    PCWre     = 1'b0;
    PCSrc     = PC_NEXT;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = ALU_ADD;
    ExtSel    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    halted    = 1'b0;

    case (state_q)
      S_IF: begin
        IRWre   = 1'b1;
        state_d = S_ID;
      end

      S_ID: begin
        if (cls.is_jump) begin
          PCWre   = 1'b1;
          PCSrc   = PC_JUMP;
          state_d = S_IF;
        end else if (cls.is_halt) begin
          state_d = S_HALT;
        end else if (cls.is_branch) begin
          state_d = S_EXE_B;
        end else if (cls.is_mem) begin
          state_d = S_EXE_LS;
        end else if (cls.is_r | cls.is_imm) begin
          state_d = S_EXE_A;
        end else begin
          PCWre   = 1'b1;
          state_d = S_IF;
        end
      end

      // ALU controls stay up through WB_A so a datapath without an ALU output latch still sees a stable result.
      S_EXE_A, S_WB_A: begin
        ALUOp   = alu_op_of(op_q);
        ALUSrcA = (op_q == OP_SLL);
        ALUSrcB = cls.is_imm;
        ExtSel  = (op_q == OP_ADDI);
        if (state_q == S_EXE_A) begin
          state_d = S_WB_A;
        end else begin
          RegWre  = 1'b1;
          RegDst  = cls.is_r;
          PCWre   = 1'b1;
          state_d = S_IF;
        end
      end

      S_EXE_B: begin
        ALUOp   = ALU_SUB;
        ExtSel  = 1'b1;
        PCWre   = 1'b1;
        PCSrc   = taken ? PC_BRANCH : PC_NEXT;
        state_d = S_IF;
      end

      // Address computation is held through MEM and WB_L so the memory address is stable while mRD/mWR are up.
      S_EXE_LS, S_MEM, S_WB_L: begin
        ALUOp   = ALU_ADD;
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        if (state_q == S_EXE_LS) begin
          state_d = S_MEM;
        end else if (state_q == S_WB_L) begin
          RegWre    = 1'b1;
          DBDataSrc = 1'b1;
          mRD       = 1'b1;
          PCWre     = 1'b1;
          state_d   = S_IF;
        end else if (op_q == OP_LW) begin
          mRD     = 1'b1;
          state_d = S_WB_L;
        end else begin
          mWR     = (op_q == OP_SW);
          PCWre   = 1'b1;
          state_d = S_IF;
        end
      end

      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end

      default: state_d = S_IF;
    endcase

    if (Reset) begin
      PCWre     = 1'b0;
      PCSrc     = PC_NEXT;
      IRWre     = 1'b0;
      RegWre    = 1'b0;
      RegDst    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = ALU_ADD;
      ExtSel    = 1'b0;
      mRD       = 1'b0;
      mWR       = 1'b0;
      DBDataSrc = 1'b0;
      halted    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control vectors are queued as stimulus is driven
// and compared at the falling edge; a second CNT_W=2 instance checks counter wrap.
module tb_multicycle_ctrl;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        PCWre, IRWre, RegWre, RegDst, ALUSrcA, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc, halted;
  logic [1:0]  PCSrc;
  logic [2:0]  ALUOp;
  logic [15:0] inst_count;

  logic        w_PCWre, w_IRWre, w_RegWre, w_RegDst, w_ALUSrcA, w_ALUSrcB, w_ExtSel, w_mRD, w_mWR;
  logic        w_DBDataSrc, w_halted;
  logic [1:0]  w_PCSrc;
  logic [2:0]  w_ALUOp;
  logic [1:0]  w_count;

  // Observed vector, MSB first: PCWre PCSrc[1:0] IRWre RegWre RegDst ALUSrcA ALUSrcB ALUOp[2:0] ExtSel mRD mWR DBDataSrc halted
  logic [15:0] obs;
  assign obs = {PCWre, PCSrc, IRWre, RegWre, RegDst, ALUSrcA, ALUSrcB, ALUOp, ExtSel, mRD, mWR, DBDataSrc, halted};

  localparam logic [15:0] M_EN  = 16'hF80D;
  localparam logic [15:0] M_ALL = 16'hFFFF;

  typedef struct {
    logic [15:0] val;
    logic [15:0] mask;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_cnt  = 0;

  always #5 CLK = ~CLK;

  multicycle_ctrl #(.CNT_W(16)) dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
    .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .halted(halted), .inst_count(inst_count)
  );

  multicycle_ctrl #(.CNT_W(2)) dut_wrap (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
    .PCWre(w_PCWre), .PCSrc(w_PCSrc), .IRWre(w_IRWre), .RegWre(w_RegWre), .RegDst(w_RegDst),
    .ALUSrcA(w_ALUSrcA), .ALUSrcB(w_ALUSrcB), .ALUOp(w_ALUOp), .ExtSel(w_ExtSel),
    .mRD(w_mRD), .mWR(w_mWR), .DBDataSrc(w_DBDataSrc), .halted(w_halted), .inst_count(w_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic cyc(input logic [5:0] op, input logic z, input logic rst,
                     input logic [15:0] ev, input logic [15:0] em, input string tag);
    exp_t e;
    opcode = op;
    zero   = z;
    Reset  = rst;
    sb.push_back('{val: ev, mask: em, tag: tag});
    @(negedge CLK);
    e = sb.pop_front();
    chk(e.tag, 32'(obs & e.mask), 32'(e.val & e.mask));
    @(posedge CLK);
    if (rst) exp_cnt = 0;
    else if (ev[15]) exp_cnt = exp_cnt + 1;
    #1;
  endtask

  function automatic logic [5:0] rnd6();
    logic [31:0] r;
    r = $urandom;
    return r[5:0];
  endfunction

  task automatic chk_cnt(input string tag);
    chk({tag, " cnt"}, 32'(inst_count), 32'(exp_cnt[15:0]));
    chk({tag, " cnt2"}, 32'(w_count), 32'(exp_cnt[1:0]));
  endtask

  // Opcode is only meaningful in ID; every other cycle gets a random value to prove op_q is used.
  task automatic run_instr(input logic [5:0] op, input logic z, input string nm);
    logic [15:0] ev, em;
    logic        is_r;
    cyc(rnd6(), z, 1'b0, 16'h1000, M_EN, {nm, " IF"});
    case (op)
      6'b111000: cyc(op, z, 1'b0, 16'hC000, M_EN, {nm, " ID"});
      6'b111111: begin
        cyc(op, z, 1'b0, 16'h0000, M_EN, {nm, " ID"});
        for (int i = 0; i < 20; i++) cyc(rnd6(), z, 1'b0, 16'h0001, M_ALL, {nm, " HALT"});
      end
      6'b110100, 6'b110101: begin
        cyc(op, z, 1'b0, 16'h0000, M_EN, {nm, " ID"});
        ev = 16'h8030;
        if ((op == 6'b110100 && z) || (op == 6'b110101 && !z)) ev = ev | 16'h2000;
        cyc(rnd6(), z, 1'b0, ev, M_EN | 16'h01F0, {nm, " EXE_B"});
      end
      6'b110000, 6'b110001: begin
        cyc(op, z, 1'b0, 16'h0000, M_EN, {nm, " ID"});
        cyc(rnd6(), z, 1'b0, 16'h0110, M_EN | 16'h01F0, {nm, " EXE_LS"});
        if (op == 6'b110000) begin
          cyc(rnd6(), z, 1'b0, 16'h8004, M_EN, {nm, " MEM"});
        end else begin
          cyc(rnd6(), z, 1'b0, 16'h0008, M_EN, {nm, " MEM"});
          cyc(rnd6(), z, 1'b0, 16'h880A, M_EN | 16'h0402, {nm, " WB_L"});
        end
      end
      6'b000000, 6'b000001, 6'b010000, 6'b010001, 6'b011000, 6'b100110,
      6'b000010, 6'b010010: begin
        is_r = 1'b1;
        em   = M_EN | 16'h03E0;
        case (op)
          6'b000001: ev = 16'h0020;
          6'b010000: ev = 16'h0060;
          6'b010001: ev = 16'h0080;
          6'b011000: ev = 16'h0240;
          6'b100110: ev = 16'h00C0;
          6'b000010: begin ev = 16'h0110; em = M_EN | 16'h03F0; is_r = 1'b0; end
          6'b010010: begin ev = 16'h0160; em = M_EN | 16'h03F0; is_r = 1'b0; end
          default:   ev = 16'h0000;
        endcase
        cyc(op, z, 1'b0, 16'h0000, M_EN, {nm, " ID"});
        cyc(rnd6(), z, 1'b0, ev, em, {nm, " EXE_A"});
        cyc(rnd6(), z, 1'b0, is_r ? 16'h8C00 : 16'h8800, M_EN | 16'h0402, {nm, " WB_A"});
      end
      default: cyc(op, z, 1'b0, 16'h8000, M_EN, {nm, " ID"});
    endcase
  endtask

  logic [5:0] op_tab [15] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                              6'b010010, 6'b011000, 6'b100110, 6'b110000, 6'b110001,
                              6'b110100, 6'b110101, 6'b111000, 6'b101010, 6'b000111};

  initial begin
    Reset  = 1'b1;
    opcode = '0;
    zero   = 1'b0;

    cyc(6'b111000, 1'b1, 1'b1, 16'h0000, M_ALL, "reset0");
    cyc(6'b111000, 1'b1, 1'b1, 16'h0000, M_ALL, "reset1");
    chk_cnt("reset");

    run_instr(6'b000000, 1'b0, "add");
    run_instr(6'b110001, 1'b0, "lw");
    chk_cnt("add_lw");

    run_instr(6'b110100, 1'b1, "beq_z1");
    run_instr(6'b110100, 1'b0, "beq_z0");
    run_instr(6'b110101, 1'b0, "bne_z0");
    run_instr(6'b110101, 1'b1, "bne_z1");
    run_instr(6'b111000, 1'b0, "j");
    run_instr(6'b101010, 1'b0, "nop");
    chk_cnt("branch_j_nop");

    run_instr(6'b000001, 1'b0, "sub");
    run_instr(6'b010000, 1'b0, "or");
    run_instr(6'b010001, 1'b0, "and");
    run_instr(6'b010010, 1'b0, "ori");
    run_instr(6'b000010, 1'b0, "addi");
    run_instr(6'b011000, 1'b0, "sll");
    run_instr(6'b100110, 1'b0, "slt");
    run_instr(6'b110000, 1'b0, "sw");
    chk_cnt("alu_sw");

    for (int i = 0; i < 30; i++) begin
      logic [31:0] r;
      r = $urandom;
      run_instr(op_tab[r % 15], r[8], "rand");
    end
    chk_cnt("rand");

    run_instr(6'b111111, 1'b0, "halt");
    chk_cnt("halt");
    cyc(rnd6(), 1'b0, 1'b1, 16'h0000, M_ALL, "halt_reset");
    chk_cnt("halt_reset");
    run_instr(6'b000000, 1'b0, "add_after_halt");

    cyc(rnd6(), 1'b0, 1'b0, 16'h1000, M_EN, "midlw IF");
    cyc(6'b110001, 1'b0, 1'b0, 16'h0000, M_EN, "midlw ID");
    cyc(rnd6(), 1'b0, 1'b0, 16'h0110, M_EN | 16'h01F0, "midlw EXE_LS");
    cyc(rnd6(), 1'b0, 1'b1, 16'h0000, M_ALL, "midlw MEM_reset");
    chk_cnt("midlw");
    cyc(rnd6(), 1'b0, 1'b0, 16'h1000, M_EN, "midlw back_IF");
    cyc(6'b101010, 1'b0, 1'b0, 16'h8000, M_EN, "midlw nop ID");

    for (int i = 0; i < 3; i++) run_instr(6'b101010, 1'b0, "wrap_nop");
    chk_cnt("wrap");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
